// File: rtl/sw_alloc_rr_if.sv
// sw_alloc_rr_if
// Bundles the request, credit and grant signals that pass between the
// input FIFOs / route computation and the switch allocator.
//
// Signals:
//   req_valid  [N_PORTS]        input i has a flit at its FIFO head
//   req_dest   [N_PORTS*SEL_W]  encoded destination per input (0 / >N_PORTS = none)
//   req_tail   [N_PORTS]        head flit of input i is a tail flit
//   credit_ret [N_PORTS]        output o's downstream freed one slot
//   sel        [N_PORTS*SEL_W]  per-output encoded granted input (i+1) or 0
//   pop        [N_PORTS]        input i dequeues at this clock edge
//   credit_err                  sticky credit overflow flag
//
// Modports:
//   master : router side (drives requests and credits, sees grants)
//   slave  : allocator side
interface sw_alloc_rr_if #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = $clog2(N_PORTS + 1)
);
  logic [N_PORTS-1:0]       req_valid;
  logic [N_PORTS*SEL_W-1:0] req_dest;
  logic [N_PORTS-1:0]       req_tail;
  logic [N_PORTS-1:0]       credit_ret;
  logic [N_PORTS*SEL_W-1:0] sel;
  logic [N_PORTS-1:0]       pop;
  logic                     credit_err;

  modport master (
    output req_valid, req_dest, req_tail, credit_ret,
    input  sel, pop, credit_err
  );

  modport slave (
    input  req_valid, req_dest, req_tail, credit_ret,
    output sel, pop, credit_err
  );
endinterface

// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr
// Stateful switch allocator for the router crossbar. Each cycle every output
// picks at most one requesting input (round-robin, or the wormhole owner
// while a packet is in flight), provided it still holds a downstream credit.
// Grants drive the crossbar select and the input FIFO pop strobes in the same
// cycle; per-output lock, owner, round-robin pointer and credit counter update
// on the following clock edge.
//
// Ports:
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : sw_alloc_rr_if.slave (requests, credits, sel, pop, credit_err)
module sw_alloc_rr #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = $clog2(N_PORTS + 1),
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  sw_alloc_rr_if.slave bus
);

  localparam int                IDX_W      = $clog2(N_PORTS);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(CREDITS);
  localparam logic [IDX_W:0]    PORTS_EXT  = (IDX_W + 1)'(N_PORTS);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PORTS - 1);

  // Per-output registered state
  logic [N_PORTS-1:0] lock;
  logic [IDX_W-1:0]   owner  [N_PORTS];
  logic [IDX_W-1:0]   rr_ptr [N_PORTS];
  logic [CNT_W-1:0]   credit [N_PORTS];
  logic               credit_err_q;

  // req_mat[o][i]: input i currently requests output o
  logic [N_PORTS-1:0] req_mat [N_PORTS];
  logic [N_PORTS-1:0] grant;
  logic [IDX_W-1:0]   grant_idx [N_PORTS];
  logic [IDX_W:0]     scan_pos;

  // Decode each input's destination code into a one-hot request per output.
  // Code 0 and codes above N_PORTS never match any output.
  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      req_mat[o] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        req_mat[o][i] = bus.req_valid[i] &&
                        (bus.req_dest[i*SEL_W +: SEL_W] == SEL_W'(o + 1));
      end
    end
  end

  // Pick one candidate per output. A locked output only considers its owner;
  // an unlocked one scans from rr_ptr upward with wrap. The scan runs from the
  // farthest offset down to offset 0 so the nearest requester is written last
  // and wins without needing an early exit. No credit means no grant.
  always_comb begin
    scan_pos = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      grant[o]     = 1'b0;
      grant_idx[o] = '0;
      if (lock[o]) begin
        grant_idx[o] = owner[o];
        grant[o]     = req_mat[o][owner[o]];
      end else begin
        for (int k = N_PORTS - 1; k >= 0; k--) begin
          scan_pos = {1'b0, rr_ptr[o]} + (IDX_W + 1)'(k);
          if (scan_pos >= PORTS_EXT) begin
            scan_pos = scan_pos - PORTS_EXT;
          end
          if (req_mat[o][scan_pos[IDX_W-1:0]]) begin
            grant[o]     = 1'b1;
            grant_idx[o] = scan_pos[IDX_W-1:0];
          end
        end
      end
      if (credit[o] == '0) begin
        grant[o] = 1'b0;
      end
    end
  end

  // Drive crossbar selects and FIFO pops from the grants. Both are forced
  // idle while reset is asserted, whatever the stale state says.
  always_comb begin
    bus.sel = '0;
    bus.pop = '0;
    if (!rst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (grant[o]) begin
          bus.sel[o*SEL_W +: SEL_W] = SEL_W'(grant_idx[o]) + SEL_W'(1);
          bus.pop[grant_idx[o]]     = 1'b1;
        end
      end
    end
  end

  assign bus.credit_err = credit_err_q;

  // State update. A non-tail grant locks the output to that input; a tail
  // grant releases the lock and moves the pointer just past the winner so it
  // gets lowest priority next time. Credits go down on a grant and up on a
  // return; both together cancel. A return into a full counter is dropped
  // and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        lock[o]   <= 1'b0;
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
        credit[o] <= CREDIT_MAX;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (grant[o]) begin
          if (bus.req_tail[grant_idx[o]]) begin
            lock[o]   <= 1'b0;
            rr_ptr[o] <= (grant_idx[o] == LAST_IDX) ? '0
                                                   : grant_idx[o] + IDX_W'(1);
          end else begin
            lock[o]  <= 1'b1;
            owner[o] <= grant_idx[o];
          end
        end

        if (grant[o] && !bus.credit_ret[o]) begin
          credit[o] <= credit[o] - CNT_W'(1);
        end else if (!grant[o] && bus.credit_ret[o]) begin
          if (credit[o] == CREDIT_MAX) begin
            credit_err_q <= 1'b1;
          end else begin
            credit[o] <= credit[o] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_rr.sv
// tb_sw_alloc_rr
// Directed bench for sw_alloc_rr with N_PORTS=5, CREDITS=4. Each step drives
// one cycle of requests just after a rising edge, then compares sel, pop and
// credit_err at the falling edge against hand-computed values.
module tb_sw_alloc_rr;

  localparam int N  = 5;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sw_alloc_rr_if #(.N_PORTS(N), .SEL_W(SW)) bus ();

  sw_alloc_rr #(
    .N_PORTS(N),
    .SEL_W  (SW),
    .CREDITS(4),
    .CNT_W  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Pack five per-port codes, port 0 in the lowest slice
  function automatic logic [N*SW-1:0] pack5(input int c0, input int c1,
                                            input int c2, input int c3,
                                            input int c4);
    return {SW'(c4), SW'(c3), SW'(c2), SW'(c1), SW'(c0)};
  endfunction

  // Wait for the next rising edge, then drive one cycle of inputs
  task automatic applyStimulus(input logic r, input logic [N-1:0] v,
                               input logic [N*SW-1:0] d, input logic [N-1:0] t,
                               input logic [N-1:0] c);
    @(posedge clk);
    #1;
    rst            = r;
    bus.req_valid  = v;
    bus.req_dest   = d;
    bus.req_tail   = t;
    bus.credit_ret = c;
    @(negedge clk);
  endtask

  // Compare the combinational grant outputs and the sticky error flag
  task automatic checkOutput(input string tag, input logic [N*SW-1:0] es,
                             input logic [N-1:0] ep, input logic ee);
    checks++;
    assert (bus.sel === es) else begin
      errors++;
      $error("[TB] FAIL %s sel: got %h expected %h", tag, bus.sel, es);
    end
    checks++;
    assert (bus.pop === ep) else begin
      errors++;
      $error("[TB] FAIL %s pop: got %b expected %b", tag, bus.pop, ep);
    end
    checks++;
    assert (bus.credit_err === ee) else begin
      errors++;
      $error("[TB] FAIL %s credit_err: got %b expected %b", tag, bus.credit_err, ee);
    end
  endtask

  task automatic runStep(input string tag, input logic r, input logic [N-1:0] v,
                         input logic [N*SW-1:0] d, input logic [N-1:0] t,
                         input logic [N-1:0] c, input logic [N*SW-1:0] es,
                         input logic [N-1:0] ep, input logic ee);
    applyStimulus(r, v, d, t, c);
    checkOutput(tag, es, ep, ee);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_dest   = '0;
    bus.req_tail   = '0;
    bus.credit_ret = '0;
    $display("[TB] start");

    // Reset holds sel/pop low even with every input requesting
    runStep("rst_a", 1, 5'b11111, pack5(1,1,1,1,1), 5'b11111, 5'b00000, '0, 5'b00000, 0);
    runStep("rst_b", 1, 5'b11111, pack5(1,1,1,1,1), 5'b11111, 5'b11111, '0, 5'b00000, 0);

    // Single flit input 0 -> output 2, then pointer check (rr_ptr[2]=1)
    runStep("single", 0, 5'b00001, pack5(3,0,0,0,0), 5'b00001, 5'b00000, pack5(0,0,1,0,0), 5'b00001, 0);
    runStep("single_ptr", 0, 5'b00011, pack5(3,3,0,0,0), 5'b00011, 5'b00000, pack5(0,0,2,0,0), 5'b00010, 0);
    runStep("bad_dest", 0, 5'b00011, pack5(0,7,0,0,0), 5'b00000, 5'b00000, '0, 5'b00000, 0);

    // Round-robin on output 4 with a credit returned every cycle
    runStep("rr_1", 0, 5'b01011, pack5(5,5,0,5,0), 5'b11111, 5'b10000, pack5(0,0,0,0,1), 5'b00001, 0);
    runStep("rr_2", 0, 5'b01011, pack5(5,5,0,5,0), 5'b11111, 5'b10000, pack5(0,0,0,0,2), 5'b00010, 0);
    runStep("rr_3", 0, 5'b01011, pack5(5,5,0,5,0), 5'b11111, 5'b10000, pack5(0,0,0,0,4), 5'b01000, 0);
    runStep("rr_ptr4", 0, 5'b10011, pack5(5,5,0,0,5), 5'b11111, 5'b10000, pack5(0,0,0,0,5), 5'b10000, 0);

    // Wormhole: input 1 owns output 0, input 2 waits through a stall bubble
    runStep("worm_head", 0, 5'b00110, pack5(0,1,1,0,0), 5'b00100, 5'b00001, pack5(2,0,0,0,0), 5'b00010, 0);
    runStep("worm_body", 0, 5'b00110, pack5(0,1,1,0,0), 5'b00100, 5'b00001, pack5(2,0,0,0,0), 5'b00010, 0);
    runStep("worm_stall", 0, 5'b00100, pack5(0,1,1,0,0), 5'b00100, 5'b00000, '0, 5'b00000, 0);
    runStep("worm_tail", 0, 5'b00110, pack5(0,1,1,0,0), 5'b00110, 5'b00001, pack5(2,0,0,0,0), 5'b00010, 0);
    runStep("worm_next", 0, 5'b00100, pack5(0,1,1,0,0), 5'b00100, 5'b00001, pack5(3,0,0,0,0), 5'b00100, 0);

    // Credit exhaustion on output 1
    for (int k = 0; k < 4; k++) begin
      runStep($sformatf("cred_grant%0d", k), 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000,
              pack5(0,1,0,0,0), 5'b00001, 0);
    end
    runStep("cred_empty", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 0);
    runStep("cred_ret", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00010, '0, 5'b00000, 0);
    runStep("cred_one", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, pack5(0,1,0,0,0), 5'b00001, 0);
    runStep("cred_empty2", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 0);

    // Refill to 2, then grant and return together keeps it at 2
    runStep("refill_1", 0, 5'b00000, pack5(2,0,0,0,0), 5'b00001, 5'b00010, '0, 5'b00000, 0);
    runStep("refill_2", 0, 5'b00000, pack5(2,0,0,0,0), 5'b00001, 5'b00010, '0, 5'b00000, 0);
    runStep("both", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00010, pack5(0,1,0,0,0), 5'b00001, 0);
    runStep("both_g1", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, pack5(0,1,0,0,0), 5'b00001, 0);
    runStep("both_g2", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, pack5(0,1,0,0,0), 5'b00001, 0);
    runStep("both_empty", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 0);

    // Refill to 4, then one overflowing return sets the sticky flag
    for (int k = 0; k < 4; k++) begin
      runStep($sformatf("fill%0d", k), 0, 5'b00000, pack5(2,0,0,0,0), 5'b00001, 5'b00010,
              '0, 5'b00000, 0);
    end
    runStep("overflow", 0, 5'b00000, pack5(2,0,0,0,0), 5'b00001, 5'b00010, '0, 5'b00000, 0);
    for (int k = 0; k < 4; k++) begin
      runStep($sformatf("after_ovf%0d", k), 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000,
              pack5(0,1,0,0,0), 5'b00001, 1);
    end
    runStep("after_ovf_empty", 0, 5'b00001, pack5(2,0,0,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 1);

    // Reset in the middle of a locked packet on output 3
    runStep("pre_single", 0, 5'b00001, pack5(4,0,0,0,0), 5'b00001, 5'b00000, pack5(0,0,0,1,0), 5'b00001, 1);
    runStep("pre_head", 0, 5'b00101, pack5(4,0,4,0,0), 5'b00001, 5'b00000, pack5(0,0,0,3,0), 5'b00100, 1);
    runStep("mid_rst_a", 1, 5'b00101, pack5(4,0,4,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 1);
    runStep("mid_rst_b", 1, 5'b00101, pack5(4,0,4,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 0);
    runStep("post_rst", 0, 5'b00101, pack5(4,0,4,0,0), 5'b00001, 5'b00000, pack5(0,0,0,1,0), 5'b00001, 0);
    for (int k = 0; k < 3; k++) begin
      runStep($sformatf("post_cred%0d", k), 0, 5'b00001, pack5(4,0,0,0,0), 5'b00001, 5'b00000,
              pack5(0,0,0,1,0), 5'b00001, 0);
    end
    runStep("post_empty", 0, 5'b00001, pack5(4,0,0,0,0), 5'b00001, 5'b00000, '0, 5'b00000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_alloc_rr.md
# sw_alloc_rr

Parametrised, stateful switch allocator for the router crossbar. Each cycle it picks at most one input per output port, drives the encoded crossbar select and the per-input FIFO pop strobes, and keeps per-output state across cycles. The per-output state is a round-robin priority pointer, a wormhole packet lock, and a downstream credit counter. It sits between the input FIFOs / route computation and the crossbar, replacing fixed select-to-pop decoding with arbitration, flow control and packet integrity.

## Interface
Parameters:
- N_PORTS, 5, number of router ports (inputs = outputs); must be ≥ 2
- SEL_W, $clog2(N_PORTS+1) = 3, width of one encoded port code; code 0 = none, code k = port k-1
- CREDITS, 4, downstream buffer depth per output; credit counter reset value and ceiling
- CNT_W, $clog2(CREDITS+1) = 3, credit counter width

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  N_PORTS  input i has a flit at its FIFO head
- req_dest  in  N_PORTS*SEL_W  encoded destination output for input i, in slice [i*SEL_W +: SEL_W]; 0 or a value > N_PORTS = no request
- req_tail  in  N_PORTS  head flit of input i is a tail flit; a single-flit packet has tail = 1
- credit_ret  in  N_PORTS  output o's downstream freed one slot this cycle
- sel  out  N_PORTS*SEL_W  per output o, encoded granted input (i+1), or 0; combinational
- pop  out  N_PORTS  input i is dequeued at this clock edge; combinational
- credit_err  out  1  sticky flag: a credit was returned to a full counter

## Operation
- Per-output registered state:
  - lock[o]: 1 bit
  - owner[o]: index 0..N_PORTS-1
  - rr_ptr[o]: index 0..N_PORTS-1
  - credit[o]: CNT_W bits
- Input i requests output o when req_valid[i]=1 and req_dest[i]=o+1. Each input requests at most one output, so grants never conflict on the input side.
- Candidate selection for output o:
  - lock[o]=1: the only candidate is owner[o]. If the owner is not requesting o, there is no grant (bubble), and the lock is held.
  - lock[o]=0: the first requesting input scanning from rr_ptr[o] upward, wrapping modulo N_PORTS.
- A grant happens when a candidate exists and credit[o] > 0. On a grant: sel[o]=i+1 and pop[i]=1. Otherwise sel[o]=0.
- A self-route (input i to output i) is legal.
- Lock/pointer update on a grant of input i to output o:
  - Non-tail flit: lock[o]=1, owner[o]=i, rr_ptr[o] unchanged.
  - Tail flit: lock[o]=0, rr_ptr[o]=(i+1) mod N_PORTS.
- Lock/pointer update with no grant: lock, owner and rr_ptr are unchanged.
- Credit update: credit[o] ← credit[o] − grant[o] + credit_ret[o].
  - A simultaneous grant and return leaves the counter unchanged.
  - A return when credit[o]=CREDITS and there is no grant leaves the counter at CREDITS and sets credit_err=1. credit_err stays 1 until reset.
- Reset values:
  - lock=0, owner=0, rr_ptr=0, credit=CREDITS, credit_err=0.
  - While rst=1, sel=0 and pop=0 regardless of inputs.
- Reset mid-packet drops the lock; the next cycle arbitrates fresh from pointer 0.

## Timing
- Decision latency 0: sel and pop are combinational from the current-cycle requests and the registered state. The input FIFO pops at the same edge.
- State updates on the clock edge that follows the decision.
- Critical path: request decode → N_PORTS-way rotating priority scan → sel/pop. There is no internal pipelining.
- Throughput: one flit per output per cycle while credits > 0. A locked output with a stalled owner idles for that cycle.

## Test plan
- Single flit: N_PORTS=5, req_valid=00001, req_dest[0]=3, req_tail=1 → sel[2]=1, pop=00001 in the same cycle; credit[2] 4→3; rr_ptr[2]=1.
- Round-robin: inputs 0, 1, 3 all request output 4 with single-flit packets, held for 3 cycles, credit_ret[4] pulsed each cycle → sel[4] = 1, 2, 4 on successive cycles; rr_ptr[4] ends at 4.
- Wormhole lock: input 1 sends 3 flits (head, body, tail) to output 0 while input 2 also requests output 0 → sel[0]=2 for 3 cycles, then 3 on the 4th; when input 1 drops req_valid mid-packet, sel[0]=0 and input 2 is still blocked.
- Credit exhaustion: CREDITS=4, input 0 streams single-flit packets to output 1 with no credit_ret → exactly 4 grants, then sel[1]=0 and pop[0]=0; one credit_ret → one more grant the following cycle.
- Simultaneous grant and return at credit[1]=2 → stays 2; credit_ret[1] with credit[1]=4 and no grant → stays 4 and credit_err=1.
- Reset mid-packet: assert rst during the body flit of a locked packet → sel=0 and pop=0 while rst=1. After release: credits=4, lock clear, and input 0 wins a contested output first.
